uart_periph: RTL and testbench



---
 rtl/uart_periph_pkg.sv | 28 ++
 rtl/uart_fifo.sv | 54 +++++
 rtl/uart_periph.sv | 273 +++++++++++++++++++++++++++
 tb/tb_uart_periph.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_periph_pkg.sv
// uart_periph_pkg: register offsets, STATUS/CTRL bit positions and the
// TX/RX FSM state types shared by the uart_periph files.
package uart_periph_pkg;

  // Register index, taken from addr[3:2]
  localparam logic [1:0] UART_REG_DATA   = 2'd0;
  localparam logic [1:0] UART_REG_STATUS = 2'd1;
  localparam logic [1:0] UART_REG_DIV    = 2'd2;
  localparam logic [1:0] UART_REG_CTRL   = 2'd3;

  // STATUS bit positions
  localparam int ST_TX_FULL      = 0;
  localparam int ST_TX_EMPTY     = 1;
  localparam int ST_RX_VALID     = 2;
  localparam int ST_RX_OVERRUN   = 3;
  localparam int ST_TX_BUSY      = 4;
  localparam int ST_TX_DROP      = 5;
  localparam int ST_RX_FRAME_ERR = 6;

  // CTRL bit positions
  localparam int CTRL_RX_IE = 0;
  localparam int CTRL_TX_IE = 1;
  localparam int CTRL_CLR   = 8;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: synchronous FIFO with full/empty flags.
// A push while full and a pop while empty are ignored; both flags are
// judged from the state before the edge.
// Ports:
//   clk, n_rst      clock, async active-low reset
//   i_push, i_data  write strobe and data
//   i_pop           read strobe (o_data shows the head entry)
//   o_data          head entry
//   o_full, o_empty occupancy flags
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;
  assign o_data    = r_mem[r_rptr];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + {{AW{1'b0}}, w_do_push} - {{AW{1'b0}}, w_do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_data;
  end

endmodule

// File: rtl/uart_periph.sv
// uart_periph: memory-mapped 8N1 UART with TX FIFO, RX holding register,
// programmable baud divisor (clocks per bit) and a level interrupt.
// Define UART_PERIPH_RX_EN to compile in the receive path; without it
// DATA reads 0, the RX status bits read 0 and uart_rx is ignored.
// Ports:
//   clk, n_rst          clock, async active-low reset
//   clk_enable          qualifies bus side effects (serial engines always run)
//   bus_r_en/addr/data  read strobe, address, combinational read data
//   bus_w_en/addr/data  write strobe, address, write data
//   uart_tx, uart_rx    serial pins
//   irq                 (rx_valid & rx_ie) | (tx_empty & tx_ie)
module uart_periph
  import uart_periph_pkg::*;
#(
  parameter int          TX_FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET     = 16'd434
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        clk_enable,
  input  logic        bus_r_en,
  input  logic [31:0] bus_r_addr,
  output logic [31:0] bus_r_data,
  input  logic        bus_w_en,
  input  logic [31:0] bus_w_addr,
  input  logic [31:0] bus_w_data,
  output logic        uart_tx,
  input  logic        uart_rx,
  output logic        irq
);
  logic        w_wr_data, w_wr_div, w_wr_ctrl, w_rd_data, w_clr;
  logic [15:0] r_div;
  logic        r_rx_ie, r_tx_ie, r_tx_drop;
  logic        w_fifo_full, w_fifo_empty;
  logic [7:0]  w_fifo_data;
  logic        w_rx_valid, w_rx_overrun, w_rx_frame_err;
  logic [7:0]  w_rx_data;

  assign w_wr_data = bus_w_en & clk_enable & (bus_w_addr[3:2] == UART_REG_DATA);
  assign w_wr_div  = bus_w_en & clk_enable & (bus_w_addr[3:2] == UART_REG_DIV);
  assign w_wr_ctrl = bus_w_en & clk_enable & (bus_w_addr[3:2] == UART_REG_CTRL);
  assign w_rd_data = bus_r_en & clk_enable & (bus_r_addr[3:2] == UART_REG_DATA);
  assign w_clr     = w_wr_ctrl & bus_w_data[CTRL_CLR];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_div     <= DIV_RESET;
      r_rx_ie   <= 1'b0;
      r_tx_ie   <= 1'b0;
      r_tx_drop <= 1'b0;
    end else begin
      // A divisor below 2 would leave no room for the half-bit RX offset
      if (w_wr_div) r_div <= (bus_w_data[15:0] < 16'd2) ? 16'd2 : bus_w_data[15:0];
      if (w_wr_ctrl) begin
        r_rx_ie <= bus_w_data[CTRL_RX_IE];
        r_tx_ie <= bus_w_data[CTRL_TX_IE];
      end
      if (w_wr_data & w_fifo_full) r_tx_drop <= 1'b1;
      else if (w_clr)              r_tx_drop <= 1'b0;
    end
  end

  // ---------------- TX ----------------
  tx_state_e   r_tx_state, w_tx_state_nxt;
  logic [15:0] r_tx_cnt, w_tx_cnt_nxt, r_tx_div, w_tx_div_nxt;
  logic [7:0]  r_tx_shift, w_tx_shift_nxt;
  logic [2:0]  r_tx_bit, w_tx_bit_nxt;
  logic        w_tx_pop, w_tx_out;

  uart_fifo #(.WIDTH(8), .DEPTH(TX_FIFO_DEPTH)) u_tx_fifo (
    .clk    (clk),
    .n_rst  (n_rst),
    .i_push (w_wr_data),
    .i_data (bus_w_data[7:0]),
    .i_pop  (w_tx_pop),
    .o_data (w_fifo_data),
    .o_full (w_fifo_full),
    .o_empty(w_fifo_empty)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_div   <= DIV_RESET;
      r_tx_shift <= '0;
      r_tx_bit   <= '0;
    end else begin
      r_tx_state <= w_tx_state_nxt;
      r_tx_cnt   <= w_tx_cnt_nxt;
      r_tx_div   <= w_tx_div_nxt;
      r_tx_shift <= w_tx_shift_nxt;
      r_tx_bit   <= w_tx_bit_nxt;
    end
  end

  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_cnt_nxt   = r_tx_cnt;
    w_tx_div_nxt   = r_tx_div;
    w_tx_shift_nxt = r_tx_shift;
    w_tx_bit_nxt   = r_tx_bit;
    w_tx_pop       = 1'b0;
    w_tx_out       = 1'b1;
    case (r_tx_state)
      TX_IDLE: w_tx_pop = ~w_fifo_empty;
      TX_START: begin
        w_tx_out = 1'b0;
        if (r_tx_cnt == '0) begin
          w_tx_state_nxt = TX_DATA;
          w_tx_cnt_nxt   = r_tx_div - 16'd1;
          w_tx_bit_nxt   = '0;
        end else w_tx_cnt_nxt = r_tx_cnt - 16'd1;
      end
      TX_DATA: begin
        w_tx_out = r_tx_shift[0];
        if (r_tx_cnt == '0) begin
          w_tx_cnt_nxt   = r_tx_div - 16'd1;
          w_tx_shift_nxt = {1'b0, r_tx_shift[7:1]};
          w_tx_bit_nxt   = r_tx_bit + 3'd1;
          if (r_tx_bit == 3'd7) w_tx_state_nxt = TX_STOP;
        end else w_tx_cnt_nxt = r_tx_cnt - 16'd1;
      end
      TX_STOP: begin
        if (r_tx_cnt == '0) begin
          w_tx_state_nxt = TX_IDLE;
          w_tx_pop       = ~w_fifo_empty;   // chain the next frame with no gap
        end else w_tx_cnt_nxt = r_tx_cnt - 16'd1;
      end
      default: w_tx_state_nxt = TX_IDLE;
    endcase
    // Frame start: the divisor is frozen here so DIV writes only affect later frames
    if (w_tx_pop) begin
      w_tx_state_nxt = TX_START;
      w_tx_div_nxt   = r_div;
      w_tx_cnt_nxt   = r_div - 16'd1;
      w_tx_shift_nxt = w_fifo_data;
    end
  end

  assign uart_tx = w_tx_out;

  // ---------------- RX ----------------
`ifdef UART_PERIPH_RX_EN
  rx_state_e   r_rx_state, w_rx_state_nxt;
  logic [1:0]  r_rx_sync;
  logic        r_rx_prev, w_rx_in, w_rx_done;
  logic [15:0] r_rx_cnt, w_rx_cnt_nxt, r_rx_div, w_rx_div_nxt;
  logic [7:0]  r_rx_shift, w_rx_shift_nxt, r_rx_data;
  logic [2:0]  r_rx_bit, w_rx_bit_nxt;
  logic        r_rx_valid, r_rx_overrun, r_rx_frame_err;

  assign w_rx_in = r_rx_sync[1];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_rx_sync      <= 2'b11;
      r_rx_prev      <= 1'b1;
      r_rx_state     <= RX_IDLE;
      r_rx_cnt       <= '0;
      r_rx_div       <= DIV_RESET;
      r_rx_shift     <= '0;
      r_rx_bit       <= '0;
      r_rx_data      <= '0;
      r_rx_valid     <= 1'b0;
      r_rx_overrun   <= 1'b0;
      r_rx_frame_err <= 1'b0;
    end else begin
      r_rx_sync  <= {r_rx_sync[0], uart_rx};
      r_rx_prev  <= w_rx_in;
      r_rx_state <= w_rx_state_nxt;
      r_rx_cnt   <= w_rx_cnt_nxt;
      r_rx_div   <= w_rx_div_nxt;
      r_rx_shift <= w_rx_shift_nxt;
      r_rx_bit   <= w_rx_bit_nxt;
      // A completing frame beats a same-edge read or clear
      if (w_rx_done) begin
        r_rx_data  <= r_rx_shift;
        r_rx_valid <= 1'b1;
      end else if (w_rd_data) r_rx_valid <= 1'b0;
      if (w_rx_done & r_rx_valid & ~w_rd_data) r_rx_overrun <= 1'b1;
      else if (w_clr)                           r_rx_overrun <= 1'b0;
      if (w_rx_done & ~w_rx_in) r_rx_frame_err <= 1'b1;
      else if (w_clr)           r_rx_frame_err <= 1'b0;
    end
  end

  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_rx_cnt_nxt   = r_rx_cnt;
    w_rx_div_nxt   = r_rx_div;
    w_rx_shift_nxt = r_rx_shift;
    w_rx_bit_nxt   = r_rx_bit;
    w_rx_done      = 1'b0;
    case (r_rx_state)
      RX_IDLE: begin
        if (r_rx_prev & ~w_rx_in) begin
          w_rx_state_nxt = RX_START;
          w_rx_div_nxt   = r_div;
          w_rx_cnt_nxt   = {1'b0, r_div[15:1]} - 16'd1;   // D/2 puts samples mid-bit
        end
      end
      RX_START: begin
        if (r_rx_cnt == '0) begin
          if (w_rx_in) w_rx_state_nxt = RX_IDLE;     // glitch
          else begin
            w_rx_state_nxt = RX_DATA;
            w_rx_cnt_nxt   = r_rx_div - 16'd1;
            w_rx_bit_nxt   = '0;
          end
        end else w_rx_cnt_nxt = r_rx_cnt - 16'd1;
      end
      RX_DATA: begin
        if (r_rx_cnt == '0) begin
          w_rx_shift_nxt = {w_rx_in, r_rx_shift[7:1]};
          w_rx_cnt_nxt   = r_rx_div - 16'd1;
          w_rx_bit_nxt   = r_rx_bit + 3'd1;
          if (r_rx_bit == 3'd7) w_rx_state_nxt = RX_STOP;
        end else w_rx_cnt_nxt = r_rx_cnt - 16'd1;
      end
      RX_STOP: begin
        if (r_rx_cnt == '0) begin
          w_rx_done      = 1'b1;
          w_rx_state_nxt = RX_IDLE;
        end else w_rx_cnt_nxt = r_rx_cnt - 16'd1;
      end
      default: w_rx_state_nxt = RX_IDLE;
    endcase
  end

  assign w_rx_valid     = r_rx_valid;
  assign w_rx_overrun   = r_rx_overrun;
  assign w_rx_frame_err = r_rx_frame_err;
  assign w_rx_data      = r_rx_data;
`else
  logic w_unused_rx;
  assign w_unused_rx    = uart_rx ^ w_rd_data;
  assign w_rx_valid     = 1'b0;
  assign w_rx_overrun   = 1'b0;
  assign w_rx_frame_err = 1'b0;
  assign w_rx_data      = 8'h00;
`endif

  // ---------------- bus read / irq ----------------
  always_comb begin
    bus_r_data = '0;
    case (bus_r_addr[3:2])
      UART_REG_DATA:   bus_r_data[7:0] = w_rx_data;
      UART_REG_STATUS: begin
        bus_r_data[ST_TX_FULL]      = w_fifo_full;
        bus_r_data[ST_TX_EMPTY]     = w_fifo_empty;
        bus_r_data[ST_RX_VALID]     = w_rx_valid;
        bus_r_data[ST_RX_OVERRUN]   = w_rx_overrun;
        bus_r_data[ST_TX_BUSY]      = (r_tx_state != TX_IDLE);
        bus_r_data[ST_TX_DROP]      = r_tx_drop;
        bus_r_data[ST_RX_FRAME_ERR] = w_rx_frame_err;
      end
      UART_REG_DIV:    bus_r_data[15:0] = r_div;
      UART_REG_CTRL: begin
        bus_r_data[CTRL_RX_IE] = r_rx_ie;
        bus_r_data[CTRL_TX_IE] = r_tx_ie;
      end
      default: bus_r_data = '0;
    endcase
  end

  assign irq = (w_rx_valid & r_rx_ie) | (w_fifo_empty & r_tx_ie);

  logic w_unused;
  assign w_unused = ^{bus_r_addr[31:4], bus_r_addr[1:0], bus_w_addr[31:4],
                      bus_w_addr[1:0], bus_w_data[31:16]};

endmodule

// File: tb/tb_uart_periph.sv
module tb_uart_periph;
  localparam logic [31:0] A_DATA   = 32'h0;
  localparam logic [31:0] A_STATUS = 32'h4;
  localparam logic [31:0] A_DIV    = 32'h8;
  localparam logic [31:0] A_CTRL   = 32'hC;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        clk_enable = 1'b1;
  logic        bus_r_en = 1'b0;
  logic [31:0] bus_r_addr = '0;
  logic [31:0] bus_r_data;
  logic        bus_w_en = 1'b0;
  logic [31:0] bus_w_addr = '0;
  logic [31:0] bus_w_data = '0;
  logic        uart_tx;
  logic        uart_rx = 1'b1;
  logic        irq;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  uart_periph dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .clk_enable(clk_enable),
    .bus_r_en  (bus_r_en),
    .bus_r_addr(bus_r_addr),
    .bus_r_data(bus_r_data),
    .bus_w_en  (bus_w_en),
    .bus_w_addr(bus_w_addr),
    .bus_w_data(bus_w_data),
    .uart_tx   (uart_tx),
    .uart_rx   (uart_rx),
    .irq       (irq)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference: the line level k clocks into an 8N1 frame of byte b at d clocks/bit
  function automatic logic frame_bit(input logic [7:0] b, input int k, input int d);
    int j;
    j = k / d;
    if (j == 0) return 1'b0;
    if (j >= 9) return 1'b1;
    return b[j-1];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus_w_addr = a;
    bus_w_data = d;
    bus_w_en   = 1'b1;
    tick();
    bus_w_en   = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input bit pop, output logic [31:0] d);
    bus_r_addr = a;
    #1;
    d = bus_r_data;
    if (pop) begin
      bus_r_en = 1'b1;
      tick();
      bus_r_en = 1'b0;
    end
  endtask

  // Drives one serial frame on uart_rx while watching STATUS.rx_valid;
  // lat = clocks from the start edge until rx_valid is seen, -1 if never.
  task automatic send_rx(input logic [7:0] b, input int d, input bit stop, output int lat);
    int l;
    l = -1;
    bus_r_addr = A_STATUS;
    fork
      begin
        uart_rx = 1'b0;
        repeat (d) tick();
        for (int i = 0; i < 8; i++) begin
          uart_rx = b[i];
          repeat (d) tick();
        end
        uart_rx = stop;
        repeat (d) tick();
        uart_rx = 1'b1;
        repeat (2*d) tick();
      end
      begin
        for (int k = 1; k <= 12*d; k++) begin
          @(posedge clk);
          #2;
          if (bus_r_data[2] === 1'b1 && l < 0) l = k;
        end
      end
    join
    lat = l;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    n_rst = 1'b0;
    #2;
    total++; if (uart_tx !== 1'b1) begin bad++; $display("FAIL reset_tx_in_reset: got %b want 1", uart_tx); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b want 0", irq); end
    repeat (3) tick();
    n_rst = 1'b1;
    tick();
    rd(A_STATUS, 0, v);
    total++; if (v !== 32'h2) begin bad++; $display("FAIL reset_status: got %h want 00000002", v); end
    rd(A_DIV, 0, v);
    total++; if (v !== 32'd434) begin bad++; $display("FAIL reset_div: got %0d want 434", v); end
    rd(A_CTRL, 0, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL reset_ctrl: got %h want 0", v); end
    rd(A_DATA, 0, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL reset_data: got %h want 0", v); end
    total++; if (uart_tx !== 1'b1) begin bad++; $display("FAIL reset_tx: got %b want 1", uart_tx); end
  endtask

  task automatic test_div();
    logic [31:0] v;
    logic [31:0] val;
    wr(A_DIV, 32'h0);
    rd(A_DIV, 0, v);
    total++; if (v !== 32'd2) begin bad++; $display("FAIL div_zero: got %0d want 2", v); end
    wr(A_DIV, 32'hFFFF_0001);
    rd(A_DIV, 0, v);
    total++; if (v !== 32'd2) begin bad++; $display("FAIL div_one: got %0d want 2", v); end
    for (int r = 0; r < 3; r++) begin
      val = $urandom_range(65535, 2);
      wr(A_DIV, val | 32'hABCD_0000);
      rd(A_DIV, 0, v);
      total++; if (v !== val) begin bad++; $display("FAIL div_rand: got %0d want %0d", v, val); end
    end
  endtask

  task automatic test_tx_frame();
    logic [31:0] v;
    logic [7:0]  b;
    int d;
    for (int rep = 0; rep < 4; rep++) begin
      d = (rep == 0) ? 4 : int'($urandom_range(5, 2));
      b = (rep == 0) ? 8'hA5 : 8'($urandom);
      wr(A_DIV, d);
      bus_r_addr = A_STATUS;
      wr(A_DATA, {24'h0, b});
      total++; if (uart_tx !== 1'b1) begin bad++; $display("FAIL tx_edgeN: got %b want 1", uart_tx); end
      for (int k = 0; k < 10*d; k++) begin
        // A divisor write mid-frame must not disturb the frame in flight
        if (k == 5) begin
          bus_w_addr = A_DIV;
          bus_w_data = 32'd7;
          bus_w_en   = 1'b1;
        end
        tick();
        bus_w_en = 1'b0;
        total++;
        if (uart_tx !== frame_bit(b, k, d)) begin
          bad++;
          $display("FAIL tx_frame b=%h d=%0d k=%0d: got %b want %b", b, d, k, uart_tx, frame_bit(b, k, d));
        end
        if (k == 0) begin
          total++; if (bus_r_data[4] !== 1'b1) begin bad++; $display("FAIL tx_busy_set: got %b want 1", bus_r_data[4]); end
        end
      end
      tick();
      rd(A_STATUS, 0, v);
      total++; if (v !== 32'h2) begin bad++; $display("FAIL tx_after_frame_status: got %h want 00000002", v); end
    end
    wr(A_CTRL, 32'h2);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_tx_empty: got %b want 1", irq); end
    wr(A_CTRL, 32'h0);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_off: got %b want 0", irq); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    logic [7:0]  q [10];
    logic        e;
    int d, fl, r;
    d = 2;
    for (int i = 0; i < 10; i++) q[i] = 8'($urandom);
    wr(A_DIV, d);
    bus_r_addr = A_STATUS;
    // First byte goes straight to the transmitter, the next 8 fill the FIFO,
    // the 10th is dropped; 9 frames follow with no gap.
    for (int k = 0; k <= 9*10*d; k++) begin
      if (k < 10) begin
        bus_w_addr = A_DATA;
        bus_w_data = {24'h0, q[k]};
        bus_w_en   = 1'b1;
      end else bus_w_en = 1'b0;
      tick();
      if (k >= 1) begin
        fl = (k - 1) / (10*d);
        r  = (k - 1) % (10*d);
        e  = frame_bit(q[fl], r, d);
        total++;
        if (uart_tx !== e) begin
          bad++;
          $display("FAIL b2b_stream frame=%0d k=%0d: got %b want %b", fl, r, uart_tx, e);
        end
      end
      if (k == 8) begin
        total++; if (bus_r_data[0] !== 1'b1 || bus_r_data[5] !== 1'b0) begin bad++; $display("FAIL b2b_full: got full=%b drop=%b want 1/0", bus_r_data[0], bus_r_data[5]); end
      end
      if (k == 9) begin
        total++; if (bus_r_data[5] !== 1'b1) begin bad++; $display("FAIL b2b_drop: got %b want 1", bus_r_data[5]); end
      end
    end
    bus_w_en = 1'b0;
    tick();
    rd(A_STATUS, 0, v);
    total++; if (v !== 32'h22) begin bad++; $display("FAIL b2b_end_status: got %h want 00000022", v); end
    wr(A_CTRL, 32'h100);
    rd(A_STATUS, 0, v);
    total++; if (v !== 32'h2) begin bad++; $display("FAIL b2b_clear: got %h want 00000002", v); end
    rd(A_CTRL, 0, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL ctrl_bit8_read: got %h want 0", v); end
  endtask

  task automatic test_clk_enable();
    logic [31:0] v;
    logic [7:0]  b;
    int d;
    d = 4;
    b = 8'($urandom);
    wr(A_DIV, d);
    wr(A_DATA, {24'h0, b});
    clk_enable = 1'b0;
    bus_w_addr = A_DATA;
    bus_w_data = 32'h5A;
    bus_w_en   = 1'b1;
    bus_r_addr = A_DATA;
    bus_r_en   = 1'b1;
    for (int k = 0; k < 10*d; k++) begin
      tick();
      total++;
      if (uart_tx !== frame_bit(b, k, d)) begin
        bad++;
        $display("FAIL cen_frame k=%0d: got %b want %b", k, uart_tx, frame_bit(b, k, d));
      end
    end
    tick();
    bus_w_addr = A_DIV;
    bus_w_data = 32'd9;
    repeat (3) tick();
    rd(A_STATUS, 0, v);
    total++; if (v !== 32'h2) begin bad++; $display("FAIL cen_no_push: got %h want 00000002", v); end
    rd(A_DIV, 0, v);
    total++; if (v !== 32'd4) begin bad++; $display("FAIL cen_no_div_write: got %0d want 4", v); end
    total++; if (uart_tx !== 1'b1) begin bad++; $display("FAIL cen_idle_tx: got %b want 1", uart_tx); end
    bus_w_en   = 1'b0;
    bus_r_en   = 1'b0;
    clk_enable = 1'b1;
  endtask

`ifdef UART_PERIPH_RX_EN
  task automatic test_rx();
    logic [31:0] v;
    logic [7:0]  b;
    int d, lat, el;
    d  = 8;
    el = (19 * d) / 2 + 3;
    wr(A_DIV, d);
    send_rx(8'h3C, d, 1'b1, lat);
    total++; if (lat < el - 1 || lat > el + 1) begin bad++; $display("FAIL rx_latency: got %0d want %0d+-1", lat, el); end
    rd(A_STATUS, 0, v);
    total++; if (v !== 32'h6) begin bad++; $display("FAIL rx_status: got %h want 00000006", v); end
    wr(A_CTRL, 32'h1);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL rx_irq: got %b want 1", irq); end
    rd(A_DATA, 1, v);
    total++; if (v !== 32'h3C) begin bad++; $display("FAIL rx_data_3c: got %h want 3c", v); end
    rd(A_STATUS, 0, v);
    total++; if (v[2] !== 1'b0) begin bad++; $display("FAIL rx_pop_clears: got %b want 0", v[2]); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL rx_irq_clear: got %b want 0", irq); end

    for (int r = 0; r < 3; r++) begin
      b = 8'($urandom);
      send_rx(b, d, 1'b1, lat);
      total++; if (lat < el - 1 || lat > el + 1) begin bad++; $display("FAIL rx_rand_latency: got %0d want %0d+-1", lat, el); end
      rd(A_DATA, 1, v);
      total++; if (v !== {24'h0, b}) begin bad++; $display("FAIL rx_rand_data: got %h want %h", v, b); end
    end

    b = 8'($urandom);
    send_rx(b, d, 1'b1, lat);
    clk_enable = 1'b0;
    bus_r_addr = A_DATA;
    bus_r_en   = 1'b1;
    repeat (3) tick();
    bus_r_en   = 1'b0;
    clk_enable = 1'b1;
    rd(A_STATUS, 0, v);
    total++; if (v[2] !== 1'b1) begin bad++; $display("FAIL rx_cen_no_pop: got %b want 1", v[2]); end
    b = 8'($urandom);
    send_rx(b, d, 1'b1, lat);
    rd(A_STATUS, 0, v);
    total++; if (v[3:2] !== 2'b11) begin bad++; $display("FAIL rx_overrun: got ovr/valid=%b want 11", v[3:2]); end
    rd(A_DATA, 1, v);
    total++; if (v !== {24'h0, b}) begin bad++; $display("FAIL rx_overrun_data: got %h want %h", v, b); end

    b = 8'($urandom);
    send_rx(b, d, 1'b0, lat);
    rd(A_STATUS, 0, v);
    total++; if (v[6] !== 1'b1 || v[2] !== 1'b1) begin bad++; $display("FAIL rx_frame_err: got ferr=%b valid=%b want 1/1", v[6], v[2]); end
    rd(A_DATA, 1, v);
    total++; if (v !== {24'h0, b}) begin bad++; $display("FAIL rx_ferr_data: got %h want %h", v, b); end

    uart_rx = 1'b0;
    repeat (d/2 - 1) tick();
    uart_rx = 1'b1;
    repeat (12*d) tick();
    rd(A_STATUS, 0, v);
    total++; if (v[2] !== 1'b0) begin bad++; $display("FAIL rx_glitch: got valid=%b want 0", v[2]); end

    wr(A_CTRL, 32'h100);
    rd(A_STATUS, 0, v);
    total++; if (v !== 32'h2) begin bad++; $display("FAIL rx_clear: got %h want 00000002", v); end
  endtask
`else
  task automatic test_rx();
    logic [31:0] v;
    int lat;
    wr(A_DIV, 8);
    send_rx(8'h3C, 8, 1'b1, lat);
    rd(A_STATUS, 0, v);
    total++; if (v !== 32'h2) begin bad++; $display("FAIL norx_status: got %h want 00000002", v); end
    rd(A_DATA, 1, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL norx_data: got %h want 0", v); end
    wr(A_CTRL, 32'h1);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL norx_irq: got %b want 0", irq); end
    wr(A_CTRL, 32'h0);
  endtask
`endif

  task automatic test_reset_midframe();
    logic [31:0] v;
    wr(A_DIV, 4);
    wr(A_DATA, 32'h0);
    repeat (3) tick();
    total++; if (uart_tx !== 1'b0) begin bad++; $display("FAIL midframe_low: got %b want 0", uart_tx); end
    n_rst = 1'b0;
    #1;
    total++; if (uart_tx !== 1'b1) begin bad++; $display("FAIL midframe_reset_tx: got %b want 1", uart_tx); end
    repeat (2) tick();
    n_rst = 1'b1;
    tick();
    rd(A_STATUS, 0, v);
    total++; if (v !== 32'h2) begin bad++; $display("FAIL midframe_status: got %h want 00000002", v); end
    rd(A_DIV, 0, v);
    total++; if (v !== 32'd434) begin bad++; $display("FAIL midframe_div: got %0d want 434", v); end
    repeat (20) tick();
    total++; if (uart_tx !== 1'b1) begin bad++; $display("FAIL midframe_discard: got %b want 1", uart_tx); end
  endtask

  initial begin
    test_reset();
    test_div();
    test_tx_frame();
    test_back_to_back();
    test_clk_enable();
    test_rx();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
